// File: rtl/reg_file.sv
// Two-read / one-write register file, register 0 hardwired to zero.
// Define REG_FILE_BYPASS_EN to forward same-cycle write data to the read ports.
module reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [AW-1:0]         rd1,
  input  logic [AW-1:0]         rd2,
  input  logic [AW-1:0]         wr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  output logic [DATA_WIDTH-1:0] rd1_data,
  output logic [DATA_WIDTH-1:0] rd2_data
);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic                  we_d;

  // Address 0 and addresses past the array hold no storage.
  function automatic logic live(input logic [AW-1:0] a);
    return (a != '0) && (32'(a) < 32'(NUM_REGS));
  endfunction

  // Qualified write strobe: drops writes to zero/unbacked addresses.
  always_comb begin
    we_d = wr_en && live(wr);
  end

  // Storage: async clear, one write per rising edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_d) begin
      regs_q[wr] <= wr_data;
    end
  end

  // Port 1 combinational read, optional write forwarding.
  always_comb begin
    rd1_data = live(rd1) ? regs_q[rd1] : '0;
`ifdef REG_FILE_BYPASS_EN
    if (we_d && (rd1 == wr)) begin
      rd1_data = wr_data;
    end
`endif
  end

  // Port 2 combinational read, optional write forwarding.
  always_comb begin
    rd2_data = live(rd2) ? regs_q[rd2] : '0;
`ifdef REG_FILE_BYPASS_EN
    if (we_d && (rd2 == wr)) begin
      rd2_data = wr_data;
    end
`endif
  end

`ifndef SYNTHESIS
  task automatic display_registers();
    for (int i = 0; i < NUM_REGS; i++) begin
      $display("r%0d = 0x%h", i, regs_q[i]);
    end
  endtask
`endif

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: reset, writes, r0, forwarding,
// asynchronous reset and write suppression during reset.
module tb_reg_file;

  logic        clk;
  logic        reset_n;
  logic [4:0]  rd1;
  logic [4:0]  rd2;
  logic [4:0]  wr;
  logic [31:0] wr_data;
  logic        wr_en;
  logic [31:0] rd1_data;
  logic [31:0] rd2_data;

  int n_cmp;
  int n_bad;

  reg_file dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .rd1      (rd1),
    .rd2      (rd2),
    .wr       (wr),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .rd1_data (rd1_data),
    .rd2_data (rd2_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef REG_FILE_BYPASS_EN
  localparam logic [31:0] FWD5 = 32'd7;
`else
  localparam logic [31:0] FWD5 = 32'd0;
`endif

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h want 0x%h", tag, obs, exp);
    end
  endtask

  task automatic wr_one(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    wr      = a;
    wr_data = d;
    wr_en   = 1'b1;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    reset_n = 1'b0;
    rd1     = 5'd2;
    rd2     = 5'd10;
    wr      = '0;
    wr_data = '0;
    wr_en   = 1'b0;
    #1;
    chk("rst_rd1", rd1_data, 32'd0);
    chk("rst_rd2", rd2_data, 32'd0);
    #19;
    reset_n = 1'b1;

    wr_one(5'd10, 32'd100);
    rd1 = 5'd2;
    rd2 = 5'd10;
    #1;
    chk("w10_rd1", rd1_data, 32'd0);
    chk("w10_rd2", rd2_data, 32'd100);

    wr_one(5'd2, 32'd50);
    #1;
    chk("w2_rd1", rd1_data, 32'd50);
    chk("w2_rd2", rd2_data, 32'd100);
    dut.display_registers();

    wr_one(5'd0, 32'hDEADBEEF);
    rd1 = 5'd0;
    #1;
    chk("r0_zero", rd1_data, 32'd0);

    rd1 = 5'd10;
    rd2 = 5'd10;
    #1;
    chk("same_rd1", rd1_data, 32'd100);
    chk("same_rd2", rd2_data, 32'd100);
    rd1 = 5'd2;
    #1;
    chk("comb_rd1", rd1_data, 32'd50);

    @(negedge clk);
    wr      = 5'd2;
    wr_data = 32'd99;
    wr_en   = 1'b0;
    @(negedge clk);
    chk("noen_r2", rd1_data, 32'd50);

    @(negedge clk);
    wr      = 5'd5;
    wr_data = 32'd7;
    wr_en   = 1'b1;
    rd1     = 5'd5;
    rd2     = 5'd10;
    #1;
    chk("pre_edge_r5", rd1_data, FWD5);
    chk("pre_edge_p2", rd2_data, 32'd100);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd2   = 5'd5;
    #1;
    chk("post_r5_p1", rd1_data, 32'd7);
    chk("post_r5_p2", rd2_data, 32'd7);

    @(negedge clk);
    rd1 = 5'd2;
    rd2 = 5'd10;
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_rd1", rd1_data, 32'd0);
    chk("arst_rd2", rd2_data, 32'd0);
    wr      = 5'd3;
    wr_data = 32'h55;
    wr_en   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wr_en   = 1'b0;
    rd1     = 5'd3;
    #1;
    chk("rst_wr3", rd1_data, 32'd0);

    @(negedge clk);
    reset_n = 1'b1;
    wr      = 5'd4;
    wr_data = 32'hA5;
    wr_en   = 1'b1;
    rd1     = 5'd4;
    rd2     = 5'd5;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    #1;
    chk("resume_r4", rd1_data, 32'hA5);
    chk("cleared_r5", rd2_data, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
